prog_ctrl: RTL and testbench
============================

PROG_CTRL -- requirements
Module: prog_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning program memory words; address width is log2(DEPTH) = 4.
REQ-002 SHALL have parameter DATA_W, default 8, meaning instruction word width.
REQ-003 SHALL have port clock, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port load_start, input, 1: begin or restart a program download.
REQ-006 SHALL have ports load_valid (input, 1), load_ready (output, 1), load_data (input, DATA_W): download byte handshake.
REQ-007 SHALL have ports run_req, halt_req and step_req, each input, 1: execution control pulses.
REQ-008 SHALL have ports bp_en (input, 1) and bp_addr (input, 4): breakpoint enable and breakpoint address.
REQ-009 SHALL have ports cpu_addr (input, 4) and cpu_data (output, DATA_W): CPU fetch port.
REQ-010 SHALL have ports cpu_reset (output, 1, active-low) and cpu_en (output, 1): CPU hold-in-reset and clock enable.
REQ-011 SHALL have ports state (output, 2) and loaded (output, 1): status.

Function
REQ-012 SHALL implement the states IDLE=0, LOAD=1, RUN=2 and HALT=3, and state SHALL equal the current state.
REQ-013 SHALL resolve simultaneous requests with the priority load_start > halt_req > step_req > run_req.
REQ-014 SHALL move to LOAD from any state on load_start, clear the write pointer to 0 and clear loaded, including when load_start arrives mid-load.
REQ-015 SHALL hold load_ready = 1 in LOAD only; when load_valid && load_ready, SHALL write load_data to mem[wptr] and increment wptr.
REQ-016 SHALL, on the write with wptr = DEPTH-1, go to IDLE on the next cycle, wrap wptr to 0 and set loaded = 1.
REQ-017 SHALL ignore load_valid outside LOAD, with no write to memory.
REQ-018 SHALL move from IDLE to RUN on run_req only if loaded = 1; otherwise IDLE SHALL persist.
REQ-019 SHALL drive cpu_reset = 0 in IDLE and LOAD, and cpu_reset = 1 in RUN and HALT.
REQ-020 SHALL drive cpu_data = mem[cpu_addr] as a combinational read in all states.
REQ-021 SHALL define bp_hit = bp_en && (cpu_addr == bp_addr) && !skip.
REQ-022 SHALL, in RUN, drive cpu_en = !bp_hit.
REQ-023 SHALL, in RUN, move to HALT on bp_hit or halt_req; the instruction at bp_addr is then not executed.
REQ-024 SHALL, in HALT, drive cpu_en = 1 for exactly the cycle in which step_req is sampled, ignoring the breakpoint, and SHALL stay in HALT.
REQ-025 SHALL, in HALT, move to RUN on run_req and set skip = 1.
REQ-026 SHALL clear skip after the first RUN cycle, so a resume from a breakpoint executes that instruction once.
REQ-027 SHALL keep cpu_en = 0 in IDLE and LOAD.
REQ-028 SHALL ignore halt_req and step_req in IDLE and LOAD, and ignore run_req in RUN.
REQ-029 SHALL make memory contents persist across run/halt transitions; only LOAD writes memory.

Reset
REQ-030 SHALL, on reset = 0 asynchronously, set state = IDLE, wptr = 0, loaded = 0, skip = 0, load_ready = 0, cpu_en = 0 and cpu_reset = 0.
REQ-031 SHALL leave memory contents unreset; cpu_data is undefined until the first complete load.
REQ-032 SHALL, on reset mid-LOAD, abandon the partial load with loaded = 0.

Structure
REQ-033 SHALL place the ctrl_state_t enum (IDLE/LOAD/RUN/HALT) and the constants PROG_DEPTH = 16 and INSTR_W = 8 in the shared types package, beside addr_t and data_t.
REQ-034 SHALL isolate the memory as one sub-module, prog_mem: DEPTH x DATA_W, one synchronous write port and one asynchronous read port.

Verification
REQ-035 SHALL cover: load_start, then bytes 0x00..0x0F with load_valid held high -> 16 writes, loaded = 1 and state = IDLE on the cycle after the 16th byte; cpu_addr = 5 gives cpu_data = 0x05.
REQ-036 SHALL cover: run_req with loaded = 0 -> state stays IDLE and cpu_reset stays 0; after a full load, run_req -> RUN, cpu_reset = 1 and cpu_en = 1.
REQ-037 SHALL cover: bp_en = 1, bp_addr = 3, RUN with cpu_addr = 3 -> cpu_en = 0 that cycle and HALT next; step_req -> cpu_en = 1 for one cycle; run_req -> the first RUN cycle has cpu_en = 1 at address 3.
REQ-038 SHALL cover: load_start after 7 bytes -> wptr = 0 and loaded = 0; 16 new bytes fully overwrite memory.
REQ-039 SHALL cover: halt_req and step_req together in RUN -> HALT with cpu_en = 0; load_start and run_req together in HALT -> LOAD.
REQ-040 SHALL cover: reset asserted mid-RUN between clock edges -> state = IDLE, cpu_en = 0 and cpu_reset = 0 immediately; memory still reads the old program after a reload-free run_req is refused (loaded = 0).

Source files
------------

// File: rtl/prog_ctrl_pkg.sv
// Shared types and constants for the program-download / debug controller.
package prog_ctrl_pkg;
    localparam int PROG_DEPTH = 16;
    localparam int INSTR_W    = 8;
    localparam int ADDR_W     = $clog2(PROG_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HALT = 2'd3
    } ctrl_state_t;

    typedef logic [ADDR_W-1:0]  addr_t;
    typedef logic [INSTR_W-1:0] data_t;
endpackage

// File: rtl/prog_mem.sv
// Program store: one synchronous write port, one asynchronous read port, no reset.
module prog_mem #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic                     clock,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/prog_ctrl.sv
// Downloads a program into prog_mem, then runs / halts / single-steps the CPU
// with one address breakpoint that is skipped once on resume.
module prog_ctrl
    import prog_ctrl_pkg::*;
#(
    parameter int DEPTH  = PROG_DEPTH,
    parameter int DATA_W = INSTR_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     load_start,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic [DATA_W-1:0]        load_data,
    input  logic                     run_req,
    input  logic                     halt_req,
    input  logic                     step_req,
    input  logic                     bp_en,
    input  logic [$clog2(DEPTH)-1:0] bp_addr,
    input  logic [$clog2(DEPTH)-1:0] cpu_addr,
    output logic [DATA_W-1:0]        cpu_data,
    output logic                     cpu_reset,
    output logic                     cpu_en,
    output logic [1:0]               state,
    output logic                     loaded
);
    localparam int AW = $clog2(DEPTH);

    ctrl_state_t     st;
    logic [AW-1:0]   wptr;
    logic            skip;
    logic            bp_hit;
    logic            do_write;

    // A restart request in the same cycle as a byte wins; that byte is dropped.
    assign do_write   = (st == LOAD) && load_valid && !load_start;
    assign bp_hit     = bp_en && (cpu_addr == bp_addr) && !skip;
    assign load_ready = (st == LOAD);
    assign cpu_reset  = (st == RUN) || (st == HALT);
    assign state      = st;

    always_comb begin
        cpu_en = 1'b0;
        case (st)
            RUN:     cpu_en = !bp_hit;
            HALT:    cpu_en = step_req && !halt_req && !load_start;
            default: cpu_en = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            st     <= IDLE;
            wptr   <= '0;
            loaded <= 1'b0;
            skip   <= 1'b0;
        end else if (load_start) begin
            st     <= LOAD;
            wptr   <= '0;
            loaded <= 1'b0;
            skip   <= 1'b0;
        end else begin
            case (st)
                LOAD: if (load_valid) begin
                    if (wptr == AW'(DEPTH-1)) begin
                        st     <= IDLE;
                        wptr   <= '0;
                        loaded <= 1'b1;
                    end else begin
                        wptr <= wptr + 1'b1;
                    end
                end
                IDLE: if (run_req && loaded) st <= RUN;
                RUN: begin
                    skip <= 1'b0;
                    if (halt_req || bp_hit) st <= HALT;
                end
                HALT: if (!halt_req && !step_req && run_req) begin
                    // Resume past the breakpoint we are parked on.
                    st   <= RUN;
                    skip <= 1'b1;
                end
                default: st <= IDLE;
            endcase
        end
    end

    prog_mem #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_mem (
        .clock (clock),
        .we    (do_write),
        .waddr (wptr),
        .wdata (load_data),
        .raddr (cpu_addr),
        .rdata (cpu_data)
    );
endmodule

// File: tb/tb_prog_ctrl.sv
// Self-checking bench for prog_ctrl: directed table, hand sequences, random vs model.
module tb_prog_ctrl;
    logic       clock = 1'b0;
    logic       reset;
    logic       load_start, load_valid, load_ready;
    logic [7:0] load_data;
    logic       run_req, halt_req, step_req, bp_en;
    logic [3:0] bp_addr, cpu_addr;
    logic [7:0] cpu_data;
    logic       cpu_reset, cpu_en, loaded;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    localparam int S_IDLE = 0, S_LOAD = 1, S_RUN = 2, S_HALT = 3;

    prog_ctrl dut (
        .clock(clock), .reset(reset), .load_start(load_start), .load_valid(load_valid),
        .load_ready(load_ready), .load_data(load_data), .run_req(run_req),
        .halt_req(halt_req), .step_req(step_req), .bp_en(bp_en), .bp_addr(bp_addr),
        .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_reset(cpu_reset),
        .cpu_en(cpu_en), .state(state), .loaded(loaded)
    );

    always #5 clock = ~clock;

    // Reference model: program image, bytes received so far, control flags.
    int         m_st;
    bit         m_ld, m_skip;
    logic [7:0] m_mem [16];
    bit         m_known [16];
    logic [7:0] pend [$];

    typedef struct {
        logic       ls, run, halt, step, bpen;
        logic [3:0] bpa, addr;
        logic [1:0] st;
        logic       en, rst;
    } vec_t;
    vec_t tbl [15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_hit();
        return bp_en && (cpu_addr == bp_addr) && !m_skip;
    endfunction

    function automatic bit m_en();
        if (m_st == S_RUN)  return !m_hit();
        if (m_st == S_HALT) return step_req && !halt_req && !load_start;
        return 1'b0;
    endfunction

    task automatic m_reset();
        m_st = S_IDLE; m_ld = 0; m_skip = 0; pend.delete();
    endtask

    task automatic m_compare();
        chk("state", 32'(state), 32'(m_st));
        chk("loaded", 32'(loaded), 32'(m_ld));
        chk("load_ready", 32'(load_ready), 32'(m_st == S_LOAD));
        chk("cpu_reset", 32'(cpu_reset), 32'(m_st >= S_RUN));
        chk("cpu_en", 32'(cpu_en), 32'(m_en()));
        if (m_known[cpu_addr]) chk("cpu_data", 32'(cpu_data), 32'(m_mem[cpu_addr]));
    endtask

    task automatic m_edge();
        bit hit;
        hit = m_hit();
        if (load_start) begin
            m_st = S_LOAD; m_ld = 0; m_skip = 0; pend.delete();
        end else if (m_st == S_LOAD) begin
            if (load_valid) begin
                m_mem[pend.size()] = load_data;
                m_known[pend.size()] = 1;
                pend.push_back(load_data);
                if (pend.size() == 16) begin
                    pend.delete(); m_ld = 1; m_st = S_IDLE;
                end
            end
        end else if (m_st == S_IDLE) begin
            if (run_req && m_ld) m_st = S_RUN;
        end else if (m_st == S_RUN) begin
            if (halt_req || hit) m_st = S_HALT;
            m_skip = 0;
        end else begin
            if (!halt_req && !step_req && run_req) begin
                m_st = S_RUN; m_skip = 1;
            end
        end
    endtask

    // One cycle: compare settled outputs, advance model, take the edge.
    task automatic cyc();
        #3;
        m_compare();
        m_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_in();
        load_start = 0; load_valid = 0; load_data = 0;
        run_req = 0; halt_req = 0; step_req = 0;
    endtask

    task automatic load_prog(input logic [7:0] base);
        load_start = 1; cyc(); load_start = 0;
        for (int i = 0; i < 16; i++) begin
            load_valid = 1; load_data = base + 8'(i);
            #1 chk("load_ready_in_load", 32'(load_ready), 32'd1);
            cyc();
        end
        load_valid = 0;
    endtask

    initial begin
        tbl[0]  = '{0,1,0,0,1,4'd3,4'd0, 2'd0,0,0};
        tbl[1]  = '{0,0,0,0,1,4'd3,4'd1, 2'd2,1,1};
        tbl[2]  = '{0,0,0,0,1,4'd3,4'd3, 2'd2,0,1};
        tbl[3]  = '{0,0,0,0,1,4'd3,4'd3, 2'd3,0,1};
        tbl[4]  = '{0,0,0,1,1,4'd3,4'd3, 2'd3,1,1};
        tbl[5]  = '{0,0,0,0,1,4'd3,4'd3, 2'd3,0,1};
        tbl[6]  = '{0,1,0,0,1,4'd3,4'd3, 2'd3,0,1};
        tbl[7]  = '{0,0,0,0,1,4'd3,4'd3, 2'd2,1,1};
        tbl[8]  = '{0,0,0,0,1,4'd3,4'd4, 2'd2,1,1};
        tbl[9]  = '{0,0,0,0,1,4'd3,4'd3, 2'd2,0,1};
        tbl[10] = '{0,1,0,0,1,4'd3,4'd3, 2'd3,0,1};
        tbl[11] = '{0,0,1,1,1,4'd3,4'd3, 2'd2,1,1};
        tbl[12] = '{0,0,0,0,1,4'd3,4'd3, 2'd3,0,1};
        tbl[13] = '{1,1,0,0,1,4'd3,4'd3, 2'd3,0,1};
        tbl[14] = '{0,0,0,0,0,4'd0,4'd0, 2'd1,0,0};

        for (int i = 0; i < 16; i++) m_known[i] = 0;
        idle_in(); bp_en = 0; bp_addr = 0; cpu_addr = 0;
        reset = 0; m_reset();
        #12;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_loaded", 32'(loaded), 32'd0);
        chk("rst_load_ready", 32'(load_ready), 32'd0);
        chk("rst_cpu_en", 32'(cpu_en), 32'd0);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd0);
        reset = 1;
        @(posedge clock); #1;

        // run refused while nothing is loaded
        run_req = 1; cyc(); run_req = 0;
        chk("norun_state", 32'(state), 32'd0);
        chk("norun_cpu_reset", 32'(cpu_reset), 32'd0);

        // full download 0x00..0x0F
        load_prog(8'h00);
        chk("load_done_state", 32'(state), 32'd0);
        chk("load_done_loaded", 32'(loaded), 32'd1);
        cpu_addr = 5;
        #1 chk("cpu_data_5", 32'(cpu_data), 32'h05);

        // run / breakpoint / step / resume / priority table
        for (int i = 0; i < 15; i++) begin
            load_start = tbl[i].ls; run_req = tbl[i].run; halt_req = tbl[i].halt;
            step_req = tbl[i].step; bp_en = tbl[i].bpen; bp_addr = tbl[i].bpa;
            cpu_addr = tbl[i].addr;
            #2;
            chk($sformatf("tbl%0d_state", i), 32'(state), 32'(tbl[i].st));
            chk($sformatf("tbl%0d_cpu_en", i), 32'(cpu_en), 32'(tbl[i].en));
            chk($sformatf("tbl%0d_cpu_reset", i), 32'(cpu_reset), 32'(tbl[i].rst));
            cyc();
        end
        idle_in(); bp_en = 0;

        // abandon after 7 bytes, then reload 0xA0..0xAF
        for (int i = 0; i < 7; i++) begin
            load_valid = 1; load_data = 8'h50 + 8'(i); cyc();
        end
        load_valid = 0; load_start = 1; cyc(); load_start = 0;
        chk("restart_state", 32'(state), 32'd1);
        chk("restart_loaded", 32'(loaded), 32'd0);
        for (int i = 0; i < 16; i++) begin
            load_valid = 1; load_data = 8'hA0 + 8'(i); cyc();
        end
        load_valid = 0;
        for (int i = 0; i < 16; i++) begin
            cpu_addr = 4'(i);
            #1 chk($sformatf("reload_data%0d", i), 32'(cpu_data), 32'(8'hA0 + 8'(i)));
        end

        // async reset in the middle of RUN
        run_req = 1; cyc(); run_req = 0; cyc();
        chk("prerst_state", 32'(state), 32'd2);
        #1 reset = 0;
        #1;
        chk("mid_rst_state", 32'(state), 32'd0);
        chk("mid_rst_cpu_en", 32'(cpu_en), 32'd0);
        chk("mid_rst_cpu_reset", 32'(cpu_reset), 32'd0);
        m_reset();
        #2 reset = 1;
        @(posedge clock); #1;
        run_req = 1; cyc(); run_req = 0; cyc();
        chk("post_rst_norun", 32'(state), 32'd0);
        cpu_addr = 7;
        #1 chk("post_rst_mem", 32'(cpu_data), 32'hA7);

        // randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            load_start = ($urandom_range(0, 39) == 0);
            load_valid = $urandom_range(0, 1);
            load_data  = 8'($urandom);
            run_req    = ($urandom_range(0, 3) == 0);
            halt_req   = ($urandom_range(0, 11) == 0);
            step_req   = ($urandom_range(0, 4) == 0);
            bp_en      = $urandom_range(0, 1);
            bp_addr    = 4'($urandom_range(0, 3));
            cpu_addr   = 4'($urandom_range(0, 7));
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
